// File: rtl/pio_req_route.sv
// PIO request router: decodes the target demux channel from the first beat of
// each completer request, discards unroutable packets, replicates the latched
// header on every beat and registers the stream through an output/skid pair.
//
// Handshake: a beat moves across an interface on a clock edge where valid and
// ready are both high; valid is never withdrawn, and the payload never changes,
// until that edge.
module pio_req_route #(
    parameter int OUT_CHNL_NUM = 4,
    parameter int SEL_LSB      = 20,
    parameter int PIO_DATA_W   = 64,
    parameter int PIO_HEAD_W   = 132
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PIO_DATA_W-1:0] s_axis_req_data,
    input  logic [PIO_HEAD_W-1:0] s_axis_req_head,
    input  logic                  s_axis_req_last,
    input  logic                  s_axis_req_valid,
    output logic                  s_axis_req_ready,
    output logic [PIO_DATA_W-1:0] m_axis_req_data,
    output logic [PIO_HEAD_W-1:0] m_axis_req_head,
    output logic                  m_axis_req_last,
    output logic                  m_axis_req_valid,
    input  logic                  m_axis_req_ready,
    output logic [2:0]            demux_sel,
    output logic [15:0]           drop_cnt
);

    typedef enum logic [1:0] {SOP = 2'd0, FWD = 2'd1, DROP = 2'd2} state_t;

    typedef struct packed {
        logic [PIO_DATA_W-1:0] data;
        logic [PIO_HEAD_W-1:0] head;
        logic                  last;
        logic [2:0]            sel;
    } beat_t;

    localparam logic [3:0] CHNL_LIM = 4'(OUT_CHNL_NUM);

    state_t                state_q, state_d;
    logic [PIO_HEAD_W-1:0] hdr_q;
    logic [2:0]            sel_q;
    beat_t                 o_q, s_q, in_beat;
    logic                  o_vld, s_vld;

    logic [2:0]            bar_id;
    logic [1:0]            sel_field;
    logic [2:0]            dec_sel;
    logic                  routable;
    logic                  in_acc;
    logic                  fwd;
    logic                  drop_first;
    logic [PIO_HEAD_W-1:0] beat_head;
    logic [2:0]            beat_sel;

    // Channel decode of the raw input header; only meaningful on a first beat.
    always_comb begin
        bar_id    = s_axis_req_head[130:128];
        sel_field = s_axis_req_head[96+SEL_LSB +: 2];
        dec_sel   = 3'd0;
        if (bar_id == 3'd2) begin
            dec_sel = 3'd1 + {1'b0, sel_field};
        end
        routable = ((bar_id == 3'd0) || (bar_id == 3'd2)) && ({1'b0, dec_sel} < CHNL_LIM);
    end

    // Skid register full blocks input, except while discarding a packet.
    assign s_axis_req_ready = (state_q == DROP) | ~s_vld;
    assign in_acc           = s_axis_req_valid & s_axis_req_ready;

    // Packet-framing FSM: next state and per-beat forward/discard decision.
    always_comb begin
        state_d    = state_q;
        fwd        = 1'b0;
        drop_first = 1'b0;
        beat_head  = hdr_q;
        beat_sel   = sel_q;
        case (state_q)
            SOP: begin
                if (in_acc) begin
                    beat_head = s_axis_req_head;
                    beat_sel  = dec_sel;
                    if (routable) begin
                        fwd = 1'b1;
                        if (!s_axis_req_last) state_d = FWD;
                    end else begin
                        drop_first = 1'b1;
                        if (!s_axis_req_last) state_d = DROP;
                    end
                end
            end
            FWD: begin
                if (in_acc) begin
                    fwd = 1'b1;
                    if (s_axis_req_last) state_d = SOP;
                end
            end
            DROP: begin
                if (in_acc && s_axis_req_last) state_d = SOP;
            end
            default: state_d = SOP;
        endcase
    end

    assign in_beat = '{data: s_axis_req_data, head: beat_head,
                       last: s_axis_req_last, sel: beat_sel};

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= SOP;
        else        state_q <= state_d;
    end

    // Header and channel latched from the first beat of a routable packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_q <= '0;
            sel_q <= 3'd0;
        end else if (state_q == SOP && in_acc && routable) begin
            hdr_q <= s_axis_req_head;
            sel_q <= dec_sel;
        end
    end

    // Output/skid pair: O feeds the demux, S catches a beat while O is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q   <= '0;
            s_q   <= '0;
            o_vld <= 1'b0;
            s_vld <= 1'b0;
        end else if (!o_vld || m_axis_req_ready) begin
            if (s_vld) begin
                o_q   <= s_q;
                o_vld <= 1'b1;
                s_vld <= fwd;
                if (fwd) s_q <= in_beat;
            end else if (fwd) begin
                o_q   <= in_beat;
                o_vld <= 1'b1;
            end else begin
                o_vld <= 1'b0;
            end
        end else if (fwd) begin
            s_q   <= in_beat;
            s_vld <= 1'b1;
        end
    end

    // Saturating count of discarded packets, bumped on their first beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                drop_cnt <= 16'd0;
        else if (drop_first && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end

    assign m_axis_req_data  = o_q.data;
    assign m_axis_req_head  = o_q.head;
    assign m_axis_req_last  = o_q.last;
    assign m_axis_req_valid = o_vld;
    assign demux_sel        = o_q.sel;

endmodule

// File: tb/tb_pio_req_route.sv
// Directed bench for pio_req_route: cycle table for routing/drop/back-to-back,
// plus hand sequences for backpressure, a 2-channel range check and reset.
module tb_pio_req_route;
    localparam int DW = 32;
    localparam int HW = 132;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic [DW-1:0] s_data = '0;
    logic [HW-1:0] s_head = '0;
    logic          s_last = 1'b0, s_valid = 1'b0, s_ready;
    logic [DW-1:0] m_data;
    logic [HW-1:0] m_head;
    logic          m_last, m_valid, m_ready = 1'b1;
    logic [2:0]    sel;
    logic [15:0]   drop;

    logic [DW-1:0] s2_data = '0;
    logic [HW-1:0] s2_head = '0;
    logic          s2_last = 1'b0, s2_valid = 1'b0, s2_ready;
    logic [DW-1:0] m2_data;
    logic [HW-1:0] m2_head;
    logic          m2_last, m2_valid;
    logic [2:0]    sel2;
    logic [15:0]   drop2;

    pio_req_route #(.OUT_CHNL_NUM(4), .SEL_LSB(20), .PIO_DATA_W(DW), .PIO_HEAD_W(HW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_req_data(s_data), .s_axis_req_head(s_head), .s_axis_req_last(s_last),
        .s_axis_req_valid(s_valid), .s_axis_req_ready(s_ready),
        .m_axis_req_data(m_data), .m_axis_req_head(m_head), .m_axis_req_last(m_last),
        .m_axis_req_valid(m_valid), .m_axis_req_ready(m_ready),
        .demux_sel(sel), .drop_cnt(drop)
    );

    pio_req_route #(.OUT_CHNL_NUM(2), .SEL_LSB(20), .PIO_DATA_W(DW), .PIO_HEAD_W(HW)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_req_data(s2_data), .s_axis_req_head(s2_head), .s_axis_req_last(s2_last),
        .s_axis_req_valid(s2_valid), .s_axis_req_ready(s2_ready),
        .m_axis_req_data(m2_data), .m_axis_req_head(m2_head), .m_axis_req_last(m2_last),
        .m_axis_req_valid(m2_valid), .m_axis_req_ready(1'b1),
        .demux_sel(sel2), .drop_cnt(drop2)
    );

    // Clock.
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [HW-1:0] mk_head(input logic wr, input logic [2:0] bar,
                                               input logic [31:0] addr, input logic [95:0] cc);
        return {wr, bar, addr, cc};
    endfunction

    typedef struct {
        logic          in_valid;
        logic [HW-1:0] in_head;
        logic          in_last;
        logic [DW-1:0] in_data;
        logic          m_ready;
        logic          exp_s_ready;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic [HW-1:0] exp_head;
        logic          exp_last;
        logic [2:0]    exp_sel;
        logic [15:0]   exp_drop;
    } vec_t;

    vec_t vecs[17];

    logic [HW-1:0] h_r, h_d, h_0, h_1, h_3, h_oor, h_jk;
    logic [DW-1:0] exp_q[$];

    task automatic apply_vec(input int i);
        vec_t v;
        v = vecs[i];
        @(negedge clk);
        s_valid = v.in_valid;
        s_head  = v.in_head;
        s_last  = v.in_last;
        s_data  = v.in_data;
        m_ready = v.m_ready;
        #1;
        check($sformatf("v%0d_s_ready", i), s_ready, v.exp_s_ready);
        @(posedge clk);
        #1;
        check($sformatf("v%0d_valid", i), m_valid, v.exp_valid);
        check($sformatf("v%0d_sel", i), sel, v.exp_sel);
        check($sformatf("v%0d_drop", i), drop, v.exp_drop);
        if (v.exp_valid) begin
            check($sformatf("v%0d_data", i), m_data, v.exp_data);
            check($sformatf("v%0d_head", i), m_head, v.exp_head);
            check($sformatf("v%0d_last", i), m_last, v.exp_last);
        end
    endtask

    initial begin
        logic [3:0]    bp_pat;
        int            n_in, n_out, cyc;
        logic          stall_prev, acc_in, acc_out;
        logic [DW-1:0] prev_data, exp_d;
        logic [HW-1:0] prev_head;
        logic          prev_last, prev_valid;
        logic [2:0]    prev_sel;

        h_r   = mk_head(1'b1, 3'd2, 32'h0020_0000, 96'hA1);
        h_d   = mk_head(1'b1, 3'd1, 32'h0000_0000, 96'hD1);
        h_0   = mk_head(1'b0, 3'd0, 32'h0000_1000, 96'hC0);
        h_1   = mk_head(1'b1, 3'd2, 32'h0000_0040, 96'hC1);
        h_3   = mk_head(1'b1, 3'd3, 32'h0000_0000, 96'hE3);
        h_oor = mk_head(1'b1, 3'd2, 32'h0030_0000, 96'hE4);
        h_jk  = mk_head(1'b0, 3'd7, 32'hFFFF_FFFF, {96{1'b1}});

        //              in: vld head   last data        mrdy | exp: srdy vld data        head  last sel   drop
        vecs[0]  = '{1'b1, h_r,   1'b0, 32'hA001, 1'b1, 1'b1, 1'b1, 32'hA001, h_r, 1'b0, 3'd3, 16'd0};
        vecs[1]  = '{1'b1, h_jk,  1'b0, 32'hA002, 1'b1, 1'b1, 1'b1, 32'hA002, h_r, 1'b0, 3'd3, 16'd0};
        vecs[2]  = '{1'b1, h_jk,  1'b1, 32'hA003, 1'b1, 1'b1, 1'b1, 32'hA003, h_r, 1'b1, 3'd3, 16'd0};
        vecs[3]  = '{1'b0, h_jk,  1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 32'h0,    h_r, 1'b0, 3'd3, 16'd0};
        vecs[4]  = '{1'b1, h_d,   1'b0, 32'hD001, 1'b1, 1'b1, 1'b0, 32'h0,    h_r, 1'b0, 3'd3, 16'd1};
        vecs[5]  = '{1'b1, h_jk,  1'b0, 32'hD002, 1'b1, 1'b1, 1'b0, 32'h0,    h_r, 1'b0, 3'd3, 16'd1};
        vecs[6]  = '{1'b1, h_jk,  1'b0, 32'hD003, 1'b1, 1'b1, 1'b0, 32'h0,    h_r, 1'b0, 3'd3, 16'd1};
        vecs[7]  = '{1'b1, h_jk,  1'b1, 32'hD004, 1'b1, 1'b1, 1'b0, 32'h0,    h_r, 1'b0, 3'd3, 16'd1};
        vecs[8]  = '{1'b1, h_0,   1'b1, 32'hB001, 1'b1, 1'b1, 1'b1, 32'hB001, h_0, 1'b1, 3'd0, 16'd1};
        vecs[9]  = '{1'b1, h_0,   1'b1, 32'hC001, 1'b1, 1'b1, 1'b1, 32'hC001, h_0, 1'b1, 3'd0, 16'd1};
        vecs[10] = '{1'b1, h_1,   1'b0, 32'hC002, 1'b1, 1'b1, 1'b1, 32'hC002, h_1, 1'b0, 3'd1, 16'd1};
        vecs[11] = '{1'b1, h_jk,  1'b1, 32'hC003, 1'b1, 1'b1, 1'b1, 32'hC003, h_1, 1'b1, 3'd1, 16'd1};
        vecs[12] = '{1'b1, h_3,   1'b1, 32'hE001, 1'b1, 1'b1, 1'b0, 32'h0,    h_1, 1'b0, 3'd1, 16'd2};
        vecs[13] = '{1'b1, h_oor, 1'b1, 32'hE002, 1'b1, 1'b1, 1'b0, 32'h0,    h_1, 1'b0, 3'd1, 16'd3};
        vecs[14] = '{1'b1, h_0,   1'b1, 32'hF001, 1'b0, 1'b1, 1'b1, 32'hF001, h_0, 1'b1, 3'd0, 16'd3};
        vecs[15] = '{1'b1, h_d,   1'b1, 32'hF002, 1'b0, 1'b1, 1'b1, 32'hF001, h_0, 1'b1, 3'd0, 16'd4};
        vecs[16] = '{1'b0, h_jk,  1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 32'h0,    h_0, 1'b0, 3'd0, 16'd4};

        // Reset block.
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", m_valid, 1'b0);
        check("rst_last", m_last, 1'b0);
        check("rst_data", m_data, '0);
        check("rst_head", m_head, '0);
        check("rst_sel", sel, 3'd0);
        check("rst_drop", drop, 16'd0);
        check("rst_s_ready", s_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: routing, drop, back-to-back, unroutable bars, drop behind a stall.
        for (int i = 0; i < 17; i++) apply_vec(i);

        // Backpressure: 8-beat packet, m_ready pattern 1,0,0,1.
        bp_pat     = 4'b1001;
        n_in       = 0;
        n_out      = 0;
        cyc        = 0;
        stall_prev = 1'b0;
        prev_data  = '0;
        prev_head  = '0;
        prev_last  = 1'b0;
        prev_valid = 1'b0;
        prev_sel   = 3'd0;
        while (n_out < 8 && cyc < 100) begin
            @(negedge clk);
            m_ready = bp_pat[cyc % 4];
            s_valid = (n_in < 8);
            s_data  = 32'hB000 + 32'(n_in);
            s_head  = (n_in == 0) ? h_1 : h_jk;
            s_last  = (n_in == 7);
            #1;
            if (stall_prev) begin
                check("bp_hold_valid", m_valid, prev_valid);
                check("bp_hold_data", m_data, prev_data);
                check("bp_hold_head", m_head, prev_head);
                check("bp_hold_last", m_last, prev_last);
                check("bp_hold_sel", sel, prev_sel);
            end
            check("bp_s_ready", s_ready, (n_in - n_out) < 2);
            acc_in  = s_valid & s_ready;
            acc_out = m_valid & m_ready;
            if (acc_out) begin
                if (exp_q.size() == 0) begin
                    check("bp_extra_beat", m_data, 32'hDEAD);
                end else begin
                    exp_d = exp_q.pop_front();
                    check("bp_data", m_data, exp_d);
                    check("bp_head", m_head, h_1);
                    check("bp_sel", sel, 3'd1);
                    check("bp_last", m_last, exp_d == 32'hB007);
                end
                n_out++;
            end
            if (acc_in) begin
                exp_q.push_back(s_data);
                n_in++;
            end
            stall_prev = m_valid & ~m_ready;
            prev_valid = m_valid;
            prev_data  = m_data;
            prev_head  = m_head;
            prev_last  = m_last;
            prev_sel   = sel;
            @(posedge clk);
            cyc++;
        end
        check("bp_beats_out", 32'(n_out), 32'd8);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = 1'b1;

        // Two-channel instance: sel=2 is out of range, sel=1 is routed.
        s2_valid = 1'b1;
        s2_head  = mk_head(1'b1, 3'd2, 32'h0010_0000, 96'h77);
        s2_last  = 1'b1;
        s2_data  = 32'h2001;
        @(posedge clk);
        #1;
        check("oor_valid", m2_valid, 1'b0);
        check("oor_drop", drop2, 16'd1);
        @(negedge clk);
        s2_head = mk_head(1'b1, 3'd2, 32'h0000_0000, 96'h78);
        s2_data = 32'h2002;
        @(posedge clk);
        #1;
        check("oor_ok_valid", m2_valid, 1'b1);
        check("oor_ok_sel", sel2, 3'd1);
        check("oor_ok_data", m2_data, 32'h2002);
        check("oor_ok_drop", drop2, 16'd1);
        @(negedge clk);
        s2_valid = 1'b0;

        // Reset mid-packet with O and S both full.
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_head  = h_1;
        s_last  = 1'b0;
        s_data  = 32'h9001;
        @(negedge clk);
        s_head  = h_jk;
        s_data  = 32'h9002;
        @(negedge clk);
        s_data  = 32'h9003;
        #1;
        check("mid_s_ready_full", s_ready, 1'b0);
        check("mid_o_data", m_data, 32'h9001);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", m_valid, 1'b0);
        check("mid_rst_last", m_last, 1'b0);
        check("mid_rst_data", m_data, '0);
        check("mid_rst_head", m_head, '0);
        check("mid_rst_sel", sel, 3'd0);
        check("mid_rst_drop", drop, 16'd0);
        check("mid_rst_s_ready", s_ready, 1'b1);
        @(negedge clk);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_head  = h_r;
        s_last  = 1'b1;
        s_data  = 32'h9100;
        @(posedge clk);
        #1;
        check("post_rst_valid", m_valid, 1'b1);
        check("post_rst_data", m_data, 32'h9100);
        check("post_rst_head", m_head, h_r);
        check("post_rst_sel", sel, 3'd3);
        check("post_rst_last", m_last, 1'b1);
        @(negedge clk);
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_drain", m_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
